// File: rtl/nios_sys_rtc_0.sv
// Time-of-day counter: divides timer ticks to seconds, keeps h:m:s,
// minute-resolution alarm, 16-bit Avalon-MM slave with level interrupt.
module nios_sys_rtc_0 #(
   parameter int unsigned TICKS_PER_SEC = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   input  logic        tick_in,
   output logic        irq
);

   localparam logic [15:0] PRESC_MAX = 16'(TICKS_PER_SEC - 1);

   logic        tick_d_q;
   logic [15:0] presc_q, presc_d;
   logic [5:0]  sec_q, sec_d;
   logic [5:0]  min_q, min_d;
   logic [4:0]  hour_q, hour_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [5:0]  alarm_min_q, alarm_min_d;
   logic [4:0]  alarm_hour_q, alarm_hour_d;
   logic        sec_event_q, sec_event_d;
   logic        alarm_hit_q, alarm_hit_d;
   logic [15:0] rdata_q, rdata_d;

   logic wr_en;
   logic wr_status, wr_ctrl, wr_sec, wr_min, wr_hour, wr_alarm;
   logic tick_pulse, advance, presc_wrap, sec_inc;
   logic sec_wrap, min_wrap, hour_wrap;
   logic sec_carry, min_carry, alarm_match;
   logic unused_wd;

   assign unused_wd = ^{writedata[15:13], writedata[7:6]};

   always_comb begin
      wr_en     = chipselect & ~write_n;
      wr_status = wr_en & (address == 3'd0);
      wr_ctrl   = wr_en & (address == 3'd1);
      wr_sec    = wr_en & (address == 3'd2);
      wr_min    = wr_en & (address == 3'd3);
      wr_hour   = wr_en & (address == 3'd4);
      wr_alarm  = wr_en & (address == 3'd5);
   end

   // A CONTROL write that stops the clock also swallows a coincident tick.
   always_comb begin
      tick_pulse = tick_in & ~tick_d_q;
      advance    = tick_pulse & ctrl_q[0] & ~(wr_ctrl & ~writedata[0]);
      presc_wrap = presc_q >= PRESC_MAX;
      sec_inc    = advance & presc_wrap;
      sec_wrap   = sec_q >= 6'd59;
      min_wrap   = min_q >= 6'd59;
      hour_wrap  = hour_q >= 5'd23;
      sec_carry  = sec_inc & ~wr_sec & sec_wrap;
      min_carry  = sec_carry & ~wr_min & min_wrap;
   end

   always_comb begin
      presc_d = presc_q;
      if (wr_sec) begin
         presc_d = '0;
      end else if (advance) begin
         presc_d = presc_wrap ? '0 : presc_q + 16'd1;
      end
   end

   always_comb begin
      sec_d  = sec_q;
      min_d  = min_q;
      hour_d = hour_q;
      if (wr_sec) begin
         sec_d = writedata[5:0];
      end else if (sec_inc) begin
         sec_d = sec_wrap ? '0 : sec_q + 6'd1;
      end
      if (wr_min) begin
         min_d = writedata[5:0];
      end else if (sec_carry) begin
         min_d = min_wrap ? '0 : min_q + 6'd1;
      end
      if (wr_hour) begin
         hour_d = writedata[4:0];
      end else if (min_carry) begin
         hour_d = hour_wrap ? '0 : hour_q + 5'd1;
      end
   end

   always_comb begin
      ctrl_d       = wr_ctrl ? writedata[3:0] : ctrl_q;
      alarm_min_d  = wr_alarm ? writedata[5:0] : alarm_min_q;
      alarm_hour_d = wr_alarm ? writedata[12:8] : alarm_hour_q;
   end

   // Flag set has priority over a coincident STATUS clear.
   always_comb begin
      alarm_match = ctrl_q[3] & sec_inc & (sec_d == 6'd0)
                  & (min_d == alarm_min_q) & (hour_d == alarm_hour_q);
      sec_event_d = wr_status ? 1'b0 : sec_event_q;
      alarm_hit_d = wr_status ? 1'b0 : alarm_hit_q;
      if (sec_inc) begin
         sec_event_d = 1'b1;
      end
      if (alarm_match) begin
         alarm_hit_d = 1'b1;
      end
   end

   always_comb begin
      rdata_d = '0;
      case (address)
         3'd0:    rdata_d = {13'b0, ctrl_q[0], alarm_hit_q, sec_event_q};
         3'd1:    rdata_d = {12'b0, ctrl_q};
         3'd2:    rdata_d = {10'b0, sec_q};
         3'd3:    rdata_d = {10'b0, min_q};
         3'd4:    rdata_d = {11'b0, hour_q};
         3'd5:    rdata_d = {3'b0, alarm_hour_q, 2'b0, alarm_min_q};
         3'd6:    rdata_d = presc_q;
         default: rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_d_q     <= 1'b0;
         presc_q      <= '0;
         sec_q        <= '0;
         min_q        <= '0;
         hour_q       <= '0;
         ctrl_q       <= '0;
         alarm_min_q  <= '0;
         alarm_hour_q <= '0;
         sec_event_q  <= 1'b0;
         alarm_hit_q  <= 1'b0;
         rdata_q      <= '0;
      end else begin
         tick_d_q     <= tick_in;
         presc_q      <= presc_d;
         sec_q        <= sec_d;
         min_q        <= min_d;
         hour_q       <= hour_d;
         ctrl_q       <= ctrl_d;
         alarm_min_q  <= alarm_min_d;
         alarm_hour_q <= alarm_hour_d;
         sec_event_q  <= sec_event_d;
         alarm_hit_q  <= alarm_hit_d;
         rdata_q      <= rdata_d;
      end
   end

   assign readdata = rdata_q;
   assign irq = (sec_event_q & ctrl_q[1]) | (alarm_hit_q & ctrl_q[2]);

endmodule

// File: doc/nios_sys_rtc_0.md
# nios_sys_rtc_0

Time-of-day counter for the clock system. It consumes the periodic timeout from the interval timer (the timer `irq` line, wired to `tick_in`) and divides it down to seconds. It keeps binary hours/minutes/seconds with a minute-resolution alarm. It is an Avalon-MM slave on the Nios data master with 16-bit data, and it raises its own interrupt on second and alarm events.

## Interface
- `TICKS_PER_SEC`, default 1000: tick rising edges per second. Legal range is 2..65535. The default matches a 1 ms timer period.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low. Every register takes its reset value immediately.
- `address` in 3: register word index.
- `chipselect` in 1: slave select.
- `write_n` in 1: write strobe, active-low. A write happens only in a cycle with `chipselect=1` and `write_n=0`.
- `writedata` in 16: write data.
- `readdata` out 16: registered read data. Reset value is 0.
- `tick_in` in 1: timer interrupt level. Only its rising edge is used.
- `irq` out 1: interrupt request, active-high, level. Reset value is 0.

## Operation
- Tick edge detect:
  - `tick_d` is a register of `tick_in`; reset value 0.
  - `tick_pulse = tick_in & ~tick_d`.
  - `tick_in` held high produces exactly one pulse.
  - If `tick_in` is already high when reset is released, the first clock edge after release yields a pulse.
- Prescaler:
  - 16-bit, reset value 0.
  - Advances only when `run=1` and `tick_pulse=1`.
  - At `TICKS_PER_SEC-1` it wraps to 0 and generates `sec_inc`. Otherwise it increments.
- Time counters (binary, not BCD):
  - `sec` is 6 bits, 0..59. `min` is 6 bits, 0..59. `hour` is 5 bits, 0..23. All reset to 0.
  - Increment rule for every counter: if the value is at or above max−1, the next value is 0; otherwise value+1.
  - Out-of-range values written by software therefore wrap to 0 on their next increment.
  - `sec` wraps into `min`, `min` wraps into `hour`, and `hour` wraps from 23 to 0.
- Register map (word address):
  - 0 STATUS:
    - Read: {13'b0, running, alarm_hit, sec_event}.
    - Any write clears `sec_event` and `alarm_hit`.
  - 1 CONTROL:
    - 4 bits, reset 0: bit0 `run`, bit1 `sec_ie`, bit2 `alarm_ie`, bit3 `alarm_en`.
    - Read back zero-extended.
  - 2 SEC: read/write the low 6 bits. A write also clears the prescaler to 0.
  - 3 MIN: read/write the low 6 bits.
  - 4 HOUR: read/write the low 5 bits.
  - 5 ALARM:
    - Bits[5:0] are `alarm_min`; bits[12:8] are `alarm_hour`. Reset 0.
    - Read returns {3'b0, alarm_hour, 2'b0, alarm_min}.
  - 6 PRESCALE: read-only current prescaler value. Writes are ignored.
  - 7: reads 0; writes are ignored.
- Status flags:
  - `sec_event` is set on every `sec_inc`.
  - `alarm_hit` is set when `alarm_en=1`, `sec_inc=1`, and the next time value equals `alarm_hour:alarm_min:00`.
  - `running` is `run`.
- Interrupt:
  - `irq = (sec_event & sec_ie) | (alarm_hit & alarm_ie)`, combinational from registers.
- Reads have no side effects. `readdata` is loaded every cycle from the read mux, whether or not `chipselect` is asserted.

## Timing
- Read latency: `readdata` shows the register selected by `address` at edge N after edge N. Masters use 1 wait-free read latency cycle.
- Writes take effect at the edge where the strobe is sampled. Readback shows the new value 2 edges later, i.e. the next read cycle.
- Tick path:
  - Edge k samples `tick_in`=1 with `tick_d`=0.
  - The prescaler and time update at edge k.
  - `sec_event` is set at edge k when `sec_inc`; `irq` asserts right after edge k.
- Simultaneous events:
  - STATUS write in the same cycle as a flag set: set wins, and the flag stays 1.
  - SEC write in the same cycle as `sec_inc`: the written `sec` is stored and the prescaler clears. No carry into `min`. `sec_event` is still set.
  - MIN or HOUR write in the same cycle as a carry into that field: the written value wins. Lower fields still update normally.
  - CONTROL write clearing `run` in the same cycle as a tick pulse: the tick is ignored.
- Reset mid-operation: all state returns to reset values asynchronously, and `irq` drops immediately.

## Test plan
Tests 1–4 build with `TICKS_PER_SEC=4`; test 5 uses the default build.
1. Reset, then write CONTROL=0x3 and apply 4 tick pulses spaced 3 cycles apart -> SEC reads 1, PRESCALE reads 0, STATUS reads 0x5, and `irq`=1 one cycle after the 4th tick edge. Then write STATUS=0 -> `irq`=0 and STATUS reads 0x4.
2. Write HOUR=23, MIN=59, SEC=59, then apply 4 ticks -> HOUR, MIN and SEC all read 0.
3. Write ALARM=0x0A1E (10:30), CONTROL=0xD, HOUR=10, MIN=29, SEC=59, then apply 4 ticks -> `alarm_hit`=1 and `irq`=1. Repeat with CONTROL=0x5 (`alarm_en`=0) -> no `alarm_hit`.
4. Hold `tick_in` high for 20 cycles with `run`=1 -> PRESCALE increments by exactly 1. With `run`=0, 8 ticks -> no counter changes.
5. STATUS write coincident with the `sec_inc` edge -> `sec_event` remains 1. SEC write of 5 coincident with `sec_inc` -> SEC=5, PRESCALE=0, MIN unchanged.
6. Assert `reset_n` low mid-count with `irq`=1 -> `irq`, `readdata` and all registers are 0 without waiting for a clock edge.
